sum_accumulator: RTL and testbench

- Downstream consumer of the 8-bit adder output (uo_out sum).
- Accepts a programmed number of sum samples over a valid/ready handshake and accumulates them into a wide running total.
- Reports completion and a sticky overflow flag, and holds the result until the next start.
- Sits between the adder stage and the output/readback logic.

---
 rtl/sum_acc_pkg.sv | 14 +
 rtl/acc_add.sv | 13 +
 rtl/sum_accumulator.sv | 110 +++++++++++
 tb/tb_sum_accumulator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator slice.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/acc_add.sv
// Unsigned ACC_W-bit adder exposing the carry out of the top bit.
module acc_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of unsigned sum samples over a
// valid/ready handshake; reports completion and a sticky overflow flag
// and holds the result until the next accepted start.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   count_nxt;
  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic               acc_carry;
  logic               xfer;
  logic               accept_start;
  logic               last_xfer;

  // Handshake and status are pure decodes of the state register so that
  // in_ready never depends combinationally on in_valid.
  assign in_ready     = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign xfer         = in_valid && in_ready;
  assign accept_start = (state_q == IDLE) && start;
  assign count_nxt    = count + CNT_W'(1);
  assign last_xfer    = xfer && (count_nxt == target_q);
  assign in_ext       = ACC_W'(in_data);

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .a     (acc_out),
    .b     (in_ext),
    .sum   (acc_sum),
    .carry (acc_carry)
  );

  // State register; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: a zero-length run goes straight to DONE, and
  // start is ignored outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_xfer) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run length is captured with start and only compared during RUN.
  always_ff @(posedge clk) begin
    if (accept_start) begin
      target_q <= len;
    end
  end

  // Result registers: cleared on an accepted start, updated per transfer,
  // otherwise held so the last result stays readable after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (accept_start) begin
      acc_out <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (xfer) begin
      acc_out <= acc_sum;
      count   <= count_nxt;
      ovf     <= ovf | acc_carry;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: two instances (ACC_W=16 and ACC_W=10)
// share one stimulus stream; expected run results are queued at start and
// popped by per-instance monitors whenever done is presented.
module tb_sum_accumulator;

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready_a, busy_a, done_a, ovf_a;
  logic [15:0] acc_a;
  logic [7:0]  count_a;
  logic        in_ready_b, busy_b, done_b, ovf_b;
  logic [9:0]  acc_b;
  logic [7:0]  count_b;

  int total = 0;
  int bad   = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .busy(busy_a), .done(done_a), .acc_out(acc_a), .count(count_a), .ovf(ovf_a)
  );

  sum_accumulator #(.DATA_W(8), .ACC_W(10), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .busy(busy_b), .done(done_b), .acc_out(acc_b), .count(count_b), .ovf(ovf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (!rst && done_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_acc", 32'(acc_a), 32'(e.acc));
        check("a_count", 32'(count_a), 32'(e.cnt));
        check("a_ovf", 32'(ovf_a), 32'(e.ovf));
      end
    end
  end

  // Monitor for the 10-bit instance.
  always @(negedge clk) begin
    if (!rst && done_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_acc", 32'(acc_b), 32'(e.acc));
        check("b_count", 32'(count_b), 32'(e.cnt));
        check("b_ovf", 32'(ovf_b), 32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] acc16, input logic [9:0] acc10,
                          input logic [7:0] cnt, input logic ovf16, input logic ovf10);
    exp_t e;
    e.acc = acc16; e.cnt = cnt; e.ovf = ovf16;
    q_a.push_back(e);
    e.acc = {6'd0, acc10}; e.cnt = cnt; e.ovf = ovf10;
    q_b.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Presents one sample and returns just after the edge that accepted it;
  // in_valid is left high so consecutive calls are back-to-back.
  task automatic xfer(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready_a && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready_a) check("xfer_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_acc"}, 32'(acc_a), 32'd0);
    check({tag, "_count"}, 32'(count_a), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_a), 32'd0);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_ready"}, 32'(in_ready_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    // Reset state
    tick(); tick();
    check_idle_zero("rst");
    rst = 1'b0;
    tick();

    // Reset mid-run after one accepted sample discards the partial run
    do_start(8'd3);
    xfer(8'h10);
    in_valid = 1'b0;
    check("midrun_acc", 32'(acc_a), 32'h10);
    check("midrun_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_idle_zero("midrst");
    tick();

    // len=3, back-to-back 0x10,0x20,0x30
    push_exp(16'h0060, 10'h060, 8'd3, 1'b0, 1'b0);
    do_start(8'd3);
    xfer(8'h10); xfer(8'h20); xfer(8'h30);
    in_valid = 1'b0;
    check("t2_done_hi", 32'(done_a), 32'd1);
    check("t2_ready_lo", 32'(in_ready_a), 32'd0);
    check("t2_busy_done", 32'(busy_a), 32'd1);
    tick();
    check("t2_done_lo", 32'(done_a), 32'd0);
    check("t2_idle", 32'(busy_a), 32'd0);
    tick();

    // len=2 with a 3-cycle gap in in_valid
    push_exp(16'h0100, 10'h100, 8'd2, 1'b0, 1'b0);
    do_start(8'd2);
    xfer(8'hFF);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_gap_ready", 32'(in_ready_a), 32'd1);
      check("t3_gap_done", 32'(done_a), 32'd0);
      tick();
    end
    check("t3_gap_count", 32'(count_a), 32'd1);
    xfer(8'h01);
    in_valid = 1'b0;
    check("t3_done_hi", 32'(done_a), 32'd1);
    tick(); tick();

    // len=5 of 0xFF: 1275 fits 16 bits, wraps to 0x0FB with carry at 10 bits
    push_exp(16'h04FB, 10'h0FB, 8'd5, 1'b0, 1'b1);
    do_start(8'd5);
    xfer(8'hFF); xfer(8'hFF); xfer(8'hFF); xfer(8'hFF);
    check("t4_ovf_before", 32'(ovf_b), 32'd0);
    check("t4_acc_before", 32'(acc_b), 32'h3FC);
    xfer(8'hFF);
    in_valid = 1'b0;
    check("t4_ovf_after", 32'(ovf_b), 32'd1);
    tick();
    check("t4_ovf_held", 32'(ovf_b), 32'd1);
    tick();

    // len=0 goes straight to DONE without accepting samples
    push_exp(16'h0000, 10'h000, 8'd0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    do_start(8'd0);
    check("t5_done_hi", 32'(done_a), 32'd1);
    check("t5_ready_lo", 32'(in_ready_a), 32'd0);
    tick();
    check("t5_ready_idle", 32'(in_ready_a), 32'd0);
    check("t5_count", 32'(count_a), 32'd0);
    in_valid = 1'b0;
    tick();

    // len=2 with a start/len=7 mid-run that must be ignored
    push_exp(16'h000C, 10'h00C, 8'd2, 1'b0, 1'b0);
    do_start(8'd2);
    xfer(8'h05);
    in_valid = 1'b0;
    start = 1'b1; len = 8'd7;
    tick();
    start = 1'b0; len = 8'd0;
    check("t6_still_run", 32'(in_ready_a), 32'd1);
    xfer(8'h07);
    in_valid = 1'b0;
    check("t6_done_hi", 32'(done_a), 32'd1);
    repeat (4) tick();
    check("t6_hold_acc", 32'(acc_a), 32'h0C);
    check("t6_hold_count", 32'(count_a), 32'd2);
    push_exp(16'h0003, 10'h003, 8'd1, 1'b0, 1'b0);
    do_start(8'd1);
    check("t6_clear_acc", 32'(acc_a), 32'd0);
    check("t6_clear_count", 32'(count_a), 32'd0);
    xfer(8'h03);
    in_valid = 1'b0;
    repeat (3) tick();

    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
